// File: rtl/simple_spi_slave_if.sv
// Wishbone register bus of simple_spi_slave: the host drives the request, the slave acknowledges.
// A request is cyc_i & stb_i; the slave answers with a one-cycle ack_o carrying dat_o, then the host drops the request.
interface simple_spi_slave_if;
  logic       cyc_i;
  logic       stb_i;
  logic       we_i;
  logic [1:0] adr_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/simple_spi_slave.sv
// SPI responder with Wishbone register access, rx/tx byte FIFOs and simple_spi-style interrupt.
// Optional macro SIMPLE_SPI_SLAVE_LSB_FIRST_EN adds SCR b0 lsbfe (LSB-first shifting).
module simple_spi_slave #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  simple_spi_slave_if.slave wb,
  output logic              inta_o,
  input  logic              sck_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic              dbg_state
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state;

  logic       spie, spe, cpol, cpha, lsbfe, ovr, udr;
  logic [2:0] sck_sync, ss_n_sync;
  logic [1:0] mosi_sync;
  logic [7:0] treg, rreg;
  logic [2:0] bcnt;
  logic       byte_done;

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_cnt, tx_cnt;

`ifdef SIMPLE_SPI_SLAVE_LSB_FIRST_EN
`else
  assign lsbfe = 1'b0;
`endif

  logic rx_empty, rx_full, tx_empty, tx_full;
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));

  // Edge detect on the synchronised copies (index 1) against the history flop (index 2).
  logic sck_rise, sck_fall, ss_fall, ss_high, sample_edge, shift_edge, mosi_s;
  assign sck_rise    = sck_sync[1] & ~sck_sync[2];
  assign sck_fall    = ~sck_sync[1] & sck_sync[2];
  assign ss_fall     = ~ss_n_sync[1] & ss_n_sync[2];
  assign ss_high     = ss_n_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign sample_edge = (cpol == cpha) ? sck_rise : sck_fall;
  assign shift_edge  = (cpol == cpha) ? sck_fall : sck_rise;

  logic bus_req, bus_rd, bus_wr;
  assign bus_req = wb.cyc_i & wb.stb_i & ~wb.ack_o;
  assign bus_rd  = bus_req & ~wb.we_i;
  assign bus_wr  = bus_req & wb.we_i;

  logic start, active_run, tx_load, tx_pop, underrun, tx_push;
  logic rx_byte, rx_push, rx_pop, overrun;
  assign start      = (state == IDLE) & spe & ss_fall;
  assign active_run = (state == ACTIVE) & spe & ~ss_high;
  assign tx_load    = start | (active_run & shift_edge & (bcnt == 3'd0) & byte_done);
  assign tx_pop     = tx_load & ~tx_empty;
  assign underrun   = tx_load & tx_empty;
  assign tx_push    = bus_wr & (wb.adr_i == 2'd2) & (~tx_full | tx_pop);
  assign rx_pop     = bus_rd & (wb.adr_i == 2'd2) & ~rx_empty;
  assign rx_byte    = active_run & sample_edge & (bcnt == 3'd7);
  assign rx_push    = rx_byte & (~rx_full | rx_pop);
  assign overrun    = rx_byte & rx_full & ~rx_pop;

  logic [7:0] rx_next, tx_next, treg_shift, rd_data;
  assign rx_next    = lsbfe ? {mosi_s, rreg[7:1]} : {rreg[6:0], mosi_s};
  assign tx_next    = tx_empty ? IDLE_BYTE : tx_mem[tx_rp];
  assign treg_shift = lsbfe ? {1'b0, treg[7:1]} : {treg[6:0], 1'b0};

  always_comb begin
    rd_data = 8'h00;
    case (wb.adr_i)
      2'd0:    rd_data = {spie, spe, 2'b00, cpol, cpha, 1'b0, lsbfe};
      2'd1:    rd_data = {~rx_empty, ovr, udr, 1'b0, tx_full, tx_empty, rx_full, rx_empty};
      2'd2:    rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp];
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wp] <= rx_next;
    if (tx_push) tx_mem[tx_wp] <= wb.dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      ss_n_sync <= '1;
      mosi_sync <= '0;
      spie      <= 1'b0;
      spe       <= 1'b0;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
`ifdef SIMPLE_SPI_SLAVE_LSB_FIRST_EN
      lsbfe     <= 1'b0;
`endif
      ovr       <= 1'b0;
      udr       <= 1'b0;
      wb.ack_o  <= 1'b0;
      wb.dat_o  <= 8'h00;
      inta_o    <= 1'b0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_cnt    <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_cnt    <= '0;
      state     <= IDLE;
      bcnt      <= 3'd0;
      byte_done <= 1'b0;
      treg      <= IDLE_BYTE;
      rreg      <= 8'h00;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck_i};
      ss_n_sync <= {ss_n_sync[1:0], ss_n_i};
      mosi_sync <= {mosi_sync[0], mosi_i};

      wb.ack_o <= bus_req;
      if (bus_rd) wb.dat_o <= rd_data;
      if (bus_wr && wb.adr_i == 2'd0) begin
        spie  <= wb.dat_i[7];
        spe   <= wb.dat_i[6];
        cpol  <= wb.dat_i[3];
        cpha  <= wb.dat_i[2];
`ifdef SIMPLE_SPI_SLAVE_LSB_FIRST_EN
        lsbfe <= wb.dat_i[0];
`endif
      end
      // A new event in the same cycle as its W1C write keeps the flag set.
      ovr    <= (ovr & ~(bus_wr & (wb.adr_i == 2'd1) & wb.dat_i[6])) | overrun;
      udr    <= (udr & ~(bus_wr & (wb.adr_i == 2'd1) & wb.dat_i[5])) | underrun;
      inta_o <= spie & (~rx_empty | ovr | udr);

      if (!spe) begin
        rx_wp  <= '0;
        rx_rp  <= '0;
        rx_cnt <= '0;
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_cnt <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + AW'(1);
        if (rx_pop)  rx_rp <= rx_rp + AW'(1);
        if (tx_push) tx_wp <= tx_wp + AW'(1);
        if (tx_pop)  tx_rp <= tx_rp + AW'(1);
        rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      end

      case (state)
        IDLE: begin
          bcnt      <= 3'd0;
          byte_done <= 1'b0;
          if (start) begin
            state <= ACTIVE;
            treg  <= tx_next;
          end
        end
        ACTIVE: begin
          if (!active_run) begin
            state <= IDLE;
            bcnt  <= 3'd0;
          end else if (sample_edge) begin
            rreg <= rx_next;
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) byte_done <= 1'b1;
          end else if (shift_edge) begin
            // The first shift edge of a cpha=1 frame holds: bit 7 is already on miso.
            if (bcnt != 3'd0)   treg <= treg_shift;
            else if (byte_done) treg <= tx_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso_o    = (state == ACTIVE) ? (lsbfe ? treg[0] : treg[7]) : 1'b1;
  assign miso_oe_o = (state == ACTIVE);
  assign dbg_state = (state == ACTIVE);
endmodule

// File: tb/tb_simple_spi_slave.sv
// Directed bench for simple_spi_slave: Wishbone host tasks, a bit-banged SPI master at clk/8,
// a table of loopback vectors across SPI modes, and hand-written FIFO/flag corner sequences.
module tb_simple_spi_slave;
  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simple_spi_slave_if bus();
  logic inta, sck, ss_n, mosi, miso, miso_oe, dbg_state;

  simple_spi_slave dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb        (bus),
    .inta_o    (inta),
    .sck_i     (sck),
    .ss_n_i    (ss_n),
    .mosi_i    (mosi),
    .miso_o    (miso),
    .miso_oe_o (miso_oe),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       oe_mid;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] host_tx;
    logic [7:0] master_tx;
    logic [7:0] exp_master_rx;
    logic [7:0] exp_sdr;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] wdat,
                         output logic [7:0] rdat);
    int n;
    @(negedge clk);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.dat_i = wdat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack_o && n < 8);
    if (!bus.ack_o) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
    end
    rdat      = bus.dat_o;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] adr, input logic [7:0] d);
    logic [7:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_rd(input logic [1:0] adr, output logic [7:0] d);
    wb_xfer(1'b0, adr, 8'h00, d);
  endtask

  // SPI master, MSB-first over the low nbits of tx, half period = 4 clk cycles.
  task automatic spi_frame(input logic [1:0] mode, input logic [15:0] tx, input int nbits,
                           output logic [15:0] rx);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    rx   = 16'h0000;
    @(negedge clk);
    sck = cpol;
    repeat (8) @(negedge clk);
    ss_n = 1'b0;
    if (!cpha) mosi = tx[nbits-1];
    repeat (8) @(negedge clk);
    oe_mid = miso_oe;
    for (int i = 0; i < nbits; i++) begin
      sck = ~cpol;
      if (cpha) mosi = tx[nbits-1-i];
      else      rx = {rx[14:0], miso};
      repeat (4) @(negedge clk);
      sck = cpol;
      if (cpha) rx = {rx[14:0], miso};
      else if (i < nbits - 1) mosi = tx[nbits-2-i];
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[5];
    logic [7:0]  d;
    logic [15:0] r16;

    vecs[0] = '{2'd0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{2'd1, 8'h81, 8'h81, 8'h81, 8'h81};
    vecs[2] = '{2'd2, 8'h81, 8'h81, 8'h81, 8'h81};
    vecs[3] = '{2'd3, 8'h81, 8'h81, 8'h81, 8'h81};
    vecs[4] = '{2'd3, 8'h5A, 8'hC3, 8'h5A, 8'hC3};

    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = 2'd0;
    bus.dat_i = 8'h00;
    sck  = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    oe_mid = 1'b0;

    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", bus.ack_o, 0);
    check("rst_dat_o", bus.dat_o, 0);
    check("rst_inta", inta, 0);
    check("rst_miso", miso, 1);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_state", dbg_state, 0);
    wb_rd(2'd0, d); check("rst_scr", d, 8'h00);
    wb_rd(2'd1, d); check("rst_ssr", d, 8'h05);

    // loopback vectors across modes
    for (int i = 0; i < 5; i++) begin
      wb_wr(2'd0, {4'h4, vecs[i].mode, 2'b00});
      wb_wr(2'd2, vecs[i].host_tx);
      spi_frame(vecs[i].mode, {8'h00, vecs[i].master_tx}, 8, r16);
      check("vec_master_rx", r16[7:0], vecs[i].exp_master_rx);
      check("vec_oe_active", oe_mid, 1);
      wb_rd(2'd1, d); check("vec_rxif_set", d[7], 1);
      wb_rd(2'd2, d); check("vec_sdr", d, vecs[i].exp_sdr);
      wb_rd(2'd1, d); check("vec_rxif_clr", d[7], 0);
    end
    check("idle_oe", miso_oe, 0);

    // underrun: two bytes with an empty tx FIFO
    wb_wr(2'd1, 8'h60);
    wb_wr(2'd0, 8'h40);
    spi_frame(2'd0, 16'h1234, 16, r16);
    check("udr_master_rx", r16, 16'hFFFF);
    wb_rd(2'd2, d); check("udr_rx0", d, 8'h12);
    wb_rd(2'd2, d); check("udr_rx1", d, 8'h34);
    wb_rd(2'd1, d); check("udr_set", d[6:5], 2'b01);
    wb_wr(2'd1, 8'h20);
    wb_rd(2'd1, d); check("udr_clr", d[5], 0);

    // tx FIFO full: fifth push dropped (mode 1 has no trailing reload)
    wb_wr(2'd0, 8'h44);
    for (int i = 0; i < 5; i++) wb_wr(2'd2, 8'h10 + 8'(i));
    wb_rd(2'd1, d); check("txfull_flags", d[3:2], 2'b10);
    for (int i = 0; i < 5; i++) begin
      spi_frame(2'd1, 16'h0000, 8, r16);
      check("txfull_master_rx", r16[7:0], (i < 4) ? 8'h10 + 8'(i) : 8'hFF);
      wb_rd(2'd2, d); check("txfull_sdr", d, 8'h00);
    end

    // rx overrun with spie
    wb_wr(2'd1, 8'h60);
    wb_wr(2'd0, 8'hC4);
    repeat (3) @(negedge clk);
    check("ovr_inta_idle", inta, 0);
    for (int i = 0; i < 5; i++) begin
      spi_frame(2'd1, {8'h00, 8'h11 * 8'(i + 1)}, 8, r16);
      if (i < 4) exp_q.push_back(8'h11 * 8'(i + 1));
    end
    wb_rd(2'd1, d); check("ovr_flags", {d[6], d[1]}, 2'b11);
    check("ovr_inta", inta, 1);
    while (exp_q.size() > 0) begin
      wb_rd(2'd2, d);
      check("ovr_rx_order", d, exp_q.pop_front());
    end
    wb_rd(2'd2, d); check("pop_empty", d, 8'h00);
    wb_rd(2'd1, d); check("pop_empty_rxempty", d[0], 1);
    wb_wr(2'd1, 8'h60);
    repeat (3) @(negedge clk);
    check("inta_cleared", inta, 0);

    // aborted partial byte, then a full byte
    wb_wr(2'd0, 8'h40);
    spi_frame(2'd0, 16'h0016, 5, r16);
    wb_rd(2'd1, d); check("partial_rxempty", d[0], 1);
    spi_frame(2'd0, 16'h0055, 8, r16);
    wb_rd(2'd2, d); check("after_partial", d, 8'h55);

    // spe cleared flushes tx FIFO
    wb_wr(2'd2, 8'h77);
    wb_rd(2'd1, d); check("flush_pre_txempty", d[2], 0);
    wb_wr(2'd0, 8'h00);
    wb_rd(2'd1, d); check("flush_txempty", d[2], 1);

    // SCR readback of unused bits
    wb_wr(2'd0, 8'hFF);
`ifdef SIMPLE_SPI_SLAVE_LSB_FIRST_EN
    wb_rd(2'd0, d); check("scr_readback", d, 8'hCD);
`else
    wb_rd(2'd0, d); check("scr_readback", d, 8'hCC);
`endif
    wb_rd(2'd3, d); check("adr3_zero", d, 8'h00);
    wb_wr(2'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
